score_tracker: RTL
==================

Name: score_tracker

Overview:
- Parametrised N-player round/match scorekeeper for the light-cycle game; successor to the fixed two-player blue/red scorer.
- Watches each player's head-pixel colour and detects crashes (colour != ALIVE_COLOR).
- Awards points to survivors, pulses a round restart to the renderer/motion blocks, and declares the match winner(s) at WIN_SCORE.
- Sits between the colour sampler and the top-level game FSM / score display.

Parameters:
- NUM_PLAYERS, 2, number of players (2..8).
- COLOR_W, 8, width of each player colour sample.
- ALIVE_COLOR, 8'h01, colour value meaning "no collision".
- WIN_SCORE, 3, points needed to win the match (1..2**SCORE_W-1).
- SCORE_W, 2, width of each score field.
- HOLDOFF_CYCLES, 4, minimum cycles in WAIT_CLEAR before crash detection re-arms (>=1).

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset_Score  in  1  asynchronous active-high reset.
- Game_State  in  3  top-level game state; 3'b0 = menu/idle, any nonzero = match active.
- player_color  in  NUM_PLAYERS*COLOR_W  packed per-player colour; player i occupies bits [i*COLOR_W +: COLOR_W].
- scores  out  NUM_PLAYERS*SCORE_W  packed registered scores; player i occupies bits [i*SCORE_W +: SCORE_W].
- reset_round  out  1  one-cycle pulse requesting a round restart.
- draw_round  out  1  one-cycle pulse, coincident with reset_round, when all players crashed in the same cycle.
- Win  out  NUM_PLAYERS  one-hot (or multi-hot on a tie) set of match winners; held.
- match_over  out  1  high while in MATCH_OVER.
- round_count  out  8  rounds completed since match start; saturates at 255.

Behaviour:
- Reset (async, Reset_Score=1): state=IDLE; scores=0; Win=0; match_over=0; reset_round=0; draw_round=0; round_count=0; holdoff counter=0.
- Game_State==0 (synchronous, any state): next state IDLE, scores/Win/round_count cleared. Takes priority over every transition below.
- crash[i] = (player_color[i] != ALIVE_COLOR), combinational. any_crash = OR of all crash bits; all_crash = AND of all crash bits.
- Registered outputs only.
- IDLE:
  - Goes to PLAY when Game_State != 0.
  - No crash evaluation in IDLE.
- PLAY:
  - On any_crash, go to ROUND_END.
  - Latch crash vector into crash_q.
  - Each player with crash[i]=0 gets score+1, saturating at WIN_SCORE.
  - If all_crash: no score changes; draw flag latched.
  - round_count increments by 1, saturating.
- ROUND_END (exactly 1 cycle):
  - reset_round=1; draw_round=1 if the draw flag is latched.
  - If any score == WIN_SCORE: Win[i] = (score[i]==WIN_SCORE), go to MATCH_OVER.
  - Otherwise load holdoff counter = HOLDOFF_CYCLES and go to WAIT_CLEAR.
  - Latency: crash visible at PLAY -> reset_round asserted in the following cycle (1-cycle latency from sampled crash).
- WAIT_CLEAR:
  - Counter decrements to 0, then holds.
  - Exit to PLAY when counter==0 AND any_crash==0, so a lingering trail colour is never double-counted.
  - Crashes seen in WAIT_CLEAR are ignored.
- MATCH_OVER:
  - match_over=1; Win and scores held; reset_round=0.
  - Leaves only via Game_State==0 (to IDLE) or reset.
- Saturation: scores never exceed WIN_SCORE.
- Multiple survivors may reach WIN_SCORE in the same round; all of their Win bits are set (tie).
- Reset asserted mid-round: all outputs return to reset values immediately (asynchronous); no pending reset_round pulse survives.
- States encoded in a 3-bit enum: IDLE, PLAY, ROUND_END, WAIT_CLEAR, MATCH_OVER. Unreachable encodings return to IDLE.

Test Plan:
- Reset, Game_State=1, all colours 8'h01 for 20 cycles -> state PLAY, scores=0, reset_round never pulses, round_count=0.
- Player0 colour=8'h05 for 1 cycle in PLAY -> next cycle reset_round=1 for exactly 1 cycle, scores[1]=1, scores[0]=0, round_count=1, draw_round=0.
- Player0 colour held at 8'h05 for 10 cycles after a crash -> only one point awarded; PLAY re-entered only after colour returns to 8'h01 and >=4 holdoff cycles have elapsed.
- Both colours !=8'h01 in the same cycle -> reset_round=1 and draw_round=1 together, scores unchanged, round_count+1.
- Player1 wins 3 rounds -> scores[1]=3, Win=2'b10, match_over=1, further crashes ignored; Game_State=0 -> scores=0, Win=0, IDLE.
- NUM_PLAYERS=4, WIN_SCORE=3: players 0 and 1 crash together with p2=p3=2 -> p2 and p3 reach 3, Win=4'b1100; also assert Reset_Score mid-WAIT_CLEAR -> all outputs zero immediately.

Source files
------------

// File: rtl/score_tracker.sv
// N-player light-cycle scorekeeper. It detects head-pixel crashes, awards survivors,
// pulses a round restart and declares the match winner(s) at WIN_SCORE.
module score_tracker #(
    parameter int                 NUM_PLAYERS    = 2,
    parameter int                 COLOR_W        = 8,
    parameter logic [COLOR_W-1:0] ALIVE_COLOR    = COLOR_W'(1),
    parameter int                 WIN_SCORE      = 3,
    parameter int                 SCORE_W        = 2,
    parameter int                 HOLDOFF_CYCLES = 4
) (
    input  logic                           Clk,
    input  logic                           Reset_Score,
    input  logic [2:0]                     Game_State,
    input  logic [NUM_PLAYERS*COLOR_W-1:0] player_color,
    output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
    output logic                           reset_round,
    output logic                           draw_round,
    output logic [NUM_PLAYERS-1:0]         Win,
    output logic                           match_over,
    output logic [7:0]                     round_count
);

    localparam int                 HOLD_W    = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [HOLD_W-1:0]  HOLD_INIT = HOLD_W'(HOLDOFF_CYCLES);
    localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PLAY       = 3'd1,
        ROUND_END  = 3'd2,
        WAIT_CLEAR = 3'd3,
        MATCH_OVER = 3'd4
    } state_t;

    state_t                 state;
    logic [HOLD_W-1:0]      hold_cnt;
    logic [NUM_PLAYERS-1:0] crash;
    logic [NUM_PLAYERS-1:0] win_vec;
    logic                   any_crash;
    logic                   all_crash;

    function automatic logic [SCORE_W-1:0] sat_inc_score(input logic [SCORE_W-1:0] s);
        return (s >= WIN_VAL) ? WIN_VAL : s + SCORE_W'(1);
    endfunction

    function automatic logic [7:0] sat_inc_count(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    always_comb begin
        crash   = '0;
        win_vec = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            crash[i]   = (player_color[i*COLOR_W +: COLOR_W] != ALIVE_COLOR);
            win_vec[i] = (scores[i*SCORE_W +: SCORE_W] == WIN_VAL);
        end
    end

    assign any_crash = |crash;
    assign all_crash = &crash;

    always_ff @(posedge Clk or posedge Reset_Score) begin
        if (Reset_Score) begin
            state       <= IDLE;
            scores      <= '0;
            Win         <= '0;
            match_over  <= 1'b0;
            reset_round <= 1'b0;
            draw_round  <= 1'b0;
            round_count <= 8'd0;
            hold_cnt    <= '0;
        end else begin
            reset_round <= 1'b0;
            draw_round  <= 1'b0;
            if (Game_State == 3'b000) begin
                state       <= IDLE;
                scores      <= '0;
                Win         <= '0;
                match_over  <= 1'b0;
                round_count <= 8'd0;
                hold_cnt    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= PLAY;
                    end
                    PLAY: begin
                        if (any_crash) begin
                            // A total wipe-out is a draw: nobody survives to score.
                            if (!all_crash) begin
                                for (int i = 0; i < NUM_PLAYERS; i++) begin
                                    if (!crash[i]) begin
                                        scores[i*SCORE_W +: SCORE_W] <=
                                            sat_inc_score(scores[i*SCORE_W +: SCORE_W]);
                                    end
                                end
                            end
                            reset_round <= 1'b1;
                            draw_round  <= all_crash;
                            round_count <= sat_inc_count(round_count);
                            state       <= ROUND_END;
                        end
                    end
                    ROUND_END: begin
                        if (|win_vec) begin
                            Win        <= win_vec;
                            match_over <= 1'b1;
                            state      <= MATCH_OVER;
                        end else begin
                            hold_cnt <= HOLD_INIT;
                            state    <= WAIT_CLEAR;
                        end
                    end
                    WAIT_CLEAR: begin
                        // Stay until the trail colour is gone so one crash scores once.
                        if (hold_cnt != '0) begin
                            hold_cnt <= hold_cnt - HOLD_W'(1);
                        end else if (!any_crash) begin
                            state <= PLAY;
                        end
                    end
                    MATCH_OVER: begin
                        state <= MATCH_OVER;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
